// File: rtl/ldm_seq.sv
// Load/store-multiple sequencer: expands a register list into one memory beat
// per selected register, in ascending order, with mode-dependent offsets.
module ldm_seq #(
   parameter int NREG   = 16,
   parameter int RC_W   = 4,
   parameter int OFF_W  = 32,
   parameter int WORD_B = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             i_is_ldm,
   input  logic             i_ldm_p,
   input  logic             i_ldm_u,
   input  logic             i_ldm_l,
   input  logic             i_ldm_w,
   input  logic [NREG-1:0]  i_reglist,
   input  logic             i_mem_rdy,
   input  logic             i_abort,
   output logic             o_ldm_hold,
   output logic             o_ldm_mem_vld,
   output logic [RC_W-1:0]  o_ldm_reg_code,
   output logic [OFF_W-1:0] o_ldm_offset,
   output logic             o_ldm_last,
   output logic             o_ldm_wb_vld,
   output logic [OFF_W-1:0] o_ldm_wb_offset,
   output logic             o_ldm_flushreq
);

   localparam int CW = RC_W + 1;

   typedef enum logic {IDLE, XFER} state_t;

   state_t           state_reg;
   logic [NREG-1:0]  rem_reg;
   logic [CW-1:0]    k_reg;
   logic [CW-1:0]    n_reg;
   logic             p_reg, u_reg, l_reg, w_reg;
   logic             flush_reg;

   // Population count of the incoming list as a ripple of partial sums.
   logic [CW-1:0]    pop_sum [0:NREG];
   assign pop_sum[0] = '0;
   generate
      for (genvar gi = 0; gi < NREG; gi++) begin : g_pop
         assign pop_sum[gi+1] = pop_sum[gi] + {{RC_W{1'b0}}, i_reglist[gi]};
      end
   endgenerate

   logic [CW-1:0]    list_n;
   assign list_n = pop_sum[NREG];

   logic [RC_W-1:0]  low_code;
   always_comb begin
      low_code = '0;
      for (int i = NREG - 1; i >= 0; i--) begin
         if (rem_reg[i]) low_code = RC_W'(i);
      end
   end

   logic            in_xfer, one_left, accept, last_accept, empty_capture;
   logic [NREG-1:0] rem_drop;

   // Clearing the lowest set bit pops the register that was just transferred.
   assign rem_drop      = rem_reg & (rem_reg - NREG'(1));
   assign in_xfer       = (state_reg == XFER);
   assign one_left      = (rem_reg != '0) && (rem_drop == '0);
   assign accept        = in_xfer && en && i_mem_rdy && !i_abort;
   assign last_accept   = accept && one_left;
   assign empty_capture = !rst && (state_reg == IDLE) && en && i_is_ldm && (list_n == '0);

   logic [OFF_W-1:0] k_ext, n_ext, idx, n_bytes;
   always_comb begin
      k_ext = OFF_W'(k_reg);
      n_ext = OFF_W'(n_reg);
      unique case ({p_reg, u_reg})
         2'b01:   idx = k_ext;
         2'b11:   idx = k_ext + OFF_W'(1);
         2'b00:   idx = k_ext + OFF_W'(1) - n_ext;
         default: idx = k_ext - n_ext;
      endcase
      n_bytes = n_ext * OFF_W'(WORD_B);
   end

   assign o_ldm_hold      = in_xfer;
   assign o_ldm_mem_vld   = in_xfer;
   assign o_ldm_reg_code  = in_xfer ? low_code : '0;
   assign o_ldm_offset    = in_xfer ? idx * OFF_W'(WORD_B) : '0;
   assign o_ldm_last      = in_xfer && one_left;
   assign o_ldm_wb_vld    = (last_accept && w_reg) || (empty_capture && i_ldm_w);
   assign o_ldm_wb_offset = (last_accept && w_reg) ? (u_reg ? n_bytes : -n_bytes) : '0;
   assign o_ldm_flushreq  = flush_reg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= IDLE;
         rem_reg   <= '0;
         k_reg     <= '0;
         n_reg     <= '0;
         p_reg     <= 1'b0;
         u_reg     <= 1'b0;
         l_reg     <= 1'b0;
         w_reg     <= 1'b0;
         flush_reg <= 1'b0;
      end else if (en) begin
         // Loading the top register redirects the PC, so the pipeline must flush.
         flush_reg <= last_accept && l_reg && rem_reg[NREG-1];
         unique case (state_reg)
            IDLE: begin
               if (i_is_ldm) begin
                  p_reg     <= i_ldm_p;
                  u_reg     <= i_ldm_u;
                  l_reg     <= i_ldm_l;
                  w_reg     <= i_ldm_w;
                  rem_reg   <= i_reglist;
                  n_reg     <= list_n;
                  k_reg     <= '0;
                  state_reg <= (list_n != '0) ? XFER : IDLE;
               end
            end
            default: begin
               if (i_abort) begin
                  rem_reg   <= '0;
                  state_reg <= IDLE;
               end else if (i_mem_rdy) begin
                  rem_reg <= rem_drop;
                  k_reg   <= k_reg + CW'(1);
                  if (one_left) state_reg <= IDLE;
               end
            end
         endcase
      end
   end

endmodule
